// File: rtl/clock_mode_ctrl.sv
// Central mode controller for the digital clock: run / time-set / alarm-set sequencing,
// increment pulses with auto-repeat, idle timeout and lamps. Define CLOCK_CTRL_BLINK_EN for blinking lamps.
module clock_mode_ctrl #(
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned HOLD_CYC  = 50000000,
    parameter int unsigned REP_CYC   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_turn,
    input  logic       key_change,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_ahour,
    output logic       inc_amin,
    output logic       sec_clr,
    output logic       run_en,
    output logic       disp_alarm,
    output logic       LD_hour,
    output logic       LD_min,
    output logic       LD_alert,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        mode_prev_q, mode_prev_d, turn_prev_q, turn_prev_d, change_prev_q, change_prev_d;
    logic        mode_stb_q, mode_stb_d, turn_stb_q, turn_stb_d, change_stb_q, change_stb_d;
    logic [31:0] hold_cnt_q, hold_cnt_d, rep_cnt_q, rep_cnt_d, idle_cnt_q, idle_cnt_d;
    logic [31:0] hold_raw, rep_raw;
    logic        rep_evt, in_set, legal, key_leave, change_act, timeout_hit, state_chg;
    logic        inc_hour_q, inc_hour_d, inc_min_q, inc_min_d;
    logic        inc_ahour_q, inc_ahour_d, inc_amin_q, inc_amin_d;
    logic        sec_clr_q, sec_clr_d, run_en_q, run_en_d, disp_alarm_q, disp_alarm_d;
    logic        ld_hour_q, ld_hour_d, ld_min_q, ld_min_d, ld_alert_q, ld_alert_d;

    assign in_set    = (state_q == T_HOUR) || (state_q == T_MIN) ||
                       (state_q == A_HOUR) || (state_q == A_MIN);
    assign legal     = in_set || (state_q == RUN);
    assign key_leave = mode_stb_q || (turn_stb_q && in_set);

    // Press strobes lag the key level by one cycle; previous-level flops reset high
    // so a key held through reset release is not seen as a press.
    always_comb begin
        mode_prev_d   = key_mode;
        turn_prev_d   = key_turn;
        change_prev_d = key_change;
        mode_stb_d    = key_mode & ~mode_prev_q;
        turn_stb_d    = key_turn & ~turn_prev_q;
        change_stb_d  = key_change & ~change_prev_q;
    end

    always_comb begin
        hold_raw = '0;
        rep_raw  = '0;
        rep_evt  = 1'b0;
        if (in_set && key_change && !key_leave) begin
            if (hold_cnt_q < HOLD_CYC) begin
                hold_raw = hold_cnt_q + 32'd1;
                rep_evt  = (hold_raw == HOLD_CYC);
            end else begin
                hold_raw = hold_cnt_q;
                rep_raw  = rep_cnt_q + 32'd1;
                if (rep_raw == REP_CYC) begin
                    rep_evt = 1'b1;
                    rep_raw = '0;
                end
            end
        end
    end

    assign change_act  = in_set && !key_leave && (change_stb_q || rep_evt);
    assign timeout_hit = (TIMEOUT_S != 0) && in_set && (idle_cnt_q == TIMEOUT_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Priority turn > mode > change > timeout; a change action only blocks the timeout.
    always_comb begin
        state_d = state_q;
        if (!legal) begin
            state_d = RUN;
        end else if (turn_stb_q && in_set) begin
            state_d = RUN;
        end else if (mode_stb_q) begin
            case (state_q)
                RUN:     state_d = T_HOUR;
                T_HOUR:  state_d = T_MIN;
                T_MIN:   state_d = A_HOUR;
                A_HOUR:  state_d = A_MIN;
                default: state_d = RUN;
            endcase
        end else if (change_act) begin
            state_d = state_q;
        end else if (timeout_hit) begin
            state_d = RUN;
        end
    end

    always_comb begin
        state_chg  = (state_d != state_q);
        hold_cnt_d = state_chg ? '0 : hold_raw;
        rep_cnt_d  = state_chg ? '0 : rep_raw;
        idle_cnt_d = idle_cnt_q;
        if (!in_set || state_chg || mode_stb_q || turn_stb_q || change_stb_q || rep_evt)
            idle_cnt_d = '0;
        else if (tick_1hz && (idle_cnt_q < TIMEOUT_S))
            idle_cnt_d = idle_cnt_q + 32'd1;
        inc_hour_d   = change_act && (state_q == T_HOUR);
        inc_min_d    = change_act && (state_q == T_MIN);
        inc_ahour_d  = change_act && (state_q == A_HOUR);
        inc_amin_d   = change_act && (state_q == A_MIN);
        sec_clr_d    = (state_q == T_MIN) && state_chg;
        run_en_d     = !((state_d == T_HOUR) || (state_d == T_MIN));
        disp_alarm_d = (state_d == A_HOUR) || (state_d == A_MIN);
        ld_hour_d    = (state_d == T_HOUR) || (state_d == A_HOUR);
        ld_min_d     = (state_d == T_MIN) || (state_d == A_MIN);
        ld_alert_d   = disp_alarm_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_prev_q   <= 1'b1;
            turn_prev_q   <= 1'b1;
            change_prev_q <= 1'b1;
            mode_stb_q    <= 1'b0;
            turn_stb_q    <= 1'b0;
            change_stb_q  <= 1'b0;
            hold_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            inc_hour_q    <= 1'b0;
            inc_min_q     <= 1'b0;
            inc_ahour_q   <= 1'b0;
            inc_amin_q    <= 1'b0;
            sec_clr_q     <= 1'b0;
            run_en_q      <= 1'b1;
            disp_alarm_q  <= 1'b0;
            ld_hour_q     <= 1'b0;
            ld_min_q      <= 1'b0;
            ld_alert_q    <= 1'b0;
        end else begin
            mode_prev_q   <= mode_prev_d;
            turn_prev_q   <= turn_prev_d;
            change_prev_q <= change_prev_d;
            mode_stb_q    <= mode_stb_d;
            turn_stb_q    <= turn_stb_d;
            change_stb_q  <= change_stb_d;
            hold_cnt_q    <= hold_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            inc_hour_q    <= inc_hour_d;
            inc_min_q     <= inc_min_d;
            inc_ahour_q   <= inc_ahour_d;
            inc_amin_q    <= inc_amin_d;
            sec_clr_q     <= sec_clr_d;
            run_en_q      <= run_en_d;
            disp_alarm_q  <= disp_alarm_d;
            ld_hour_q     <= ld_hour_d;
            ld_min_q      <= ld_min_d;
            ld_alert_q    <= ld_alert_d;
        end
    end

`ifdef CLOCK_CTRL_BLINK_EN
    logic blink_q, blink_d;

    // Phase restarts on at state entry and is held on right after an increment.
    always_comb begin
        blink_d = blink_q;
        if (state_chg)
            blink_d = 1'b1;
        else if (inc_hour_q || inc_min_q || inc_ahour_q || inc_amin_q)
            blink_d = 1'b1;
        else if (tick_1hz)
            blink_d = ~blink_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_q <= 1'b1;
        else        blink_q <= blink_d;
    end

    assign LD_hour = ld_hour_q & blink_q;
    assign LD_min  = ld_min_q & blink_q;
`else
    assign LD_hour = ld_hour_q;
    assign LD_min  = ld_min_q;
`endif

    assign inc_hour   = inc_hour_q;
    assign inc_min    = inc_min_q;
    assign inc_ahour  = inc_ahour_q;
    assign inc_amin   = inc_amin_q;
    assign sec_clr    = sec_clr_q;
    assign run_en     = run_en_q;
    assign disp_alarm = disp_alarm_q;
    assign LD_alert   = ld_alert_q;
    assign state      = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: main instance with short hold/repeat/timeout values,
// second instance with timeout disabled for the lamp sequence.
module tb_clock_mode_ctrl;

    logic       clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0;
    logic       key_mode = 1'b0, key_turn = 1'b0, key_change = 1'b0;
    logic       inc_hour, inc_min, inc_ahour, inc_amin, sec_clr, run_en, disp_alarm;
    logic       LD_hour, LD_min, LD_alert;
    logic [2:0] state;
    logic       b_inc_hour, b_inc_min, b_inc_ahour, b_inc_amin, b_sec_clr, b_run_en, b_disp_alarm;
    logic       b_LD_hour, b_LD_min, b_LD_alert;
    logic [2:0] b_state;

    int checks = 0, passed = 0;
    int n_hour = 0, n_min = 0, n_ahour = 0, n_amin = 0, n_sec = 0;

    clock_mode_ctrl #(.TIMEOUT_S(3), .HOLD_CYC(20), .REP_CYC(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .key_mode(key_mode), .key_turn(key_turn), .key_change(key_change),
        .inc_hour(inc_hour), .inc_min(inc_min), .inc_ahour(inc_ahour), .inc_amin(inc_amin),
        .sec_clr(sec_clr), .run_en(run_en), .disp_alarm(disp_alarm),
        .LD_hour(LD_hour), .LD_min(LD_min), .LD_alert(LD_alert), .state(state)
    );

    clock_mode_ctrl #(.TIMEOUT_S(0), .HOLD_CYC(20), .REP_CYC(5)) u_dut_noto (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .key_mode(key_mode), .key_turn(key_turn), .key_change(key_change),
        .inc_hour(b_inc_hour), .inc_min(b_inc_min), .inc_ahour(b_inc_ahour), .inc_amin(b_inc_amin),
        .sec_clr(b_sec_clr), .run_en(b_run_en), .disp_alarm(b_disp_alarm),
        .LD_hour(b_LD_hour), .LD_min(b_LD_min), .LD_alert(b_LD_alert), .state(b_state)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Pulse counters for the main instance, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (inc_hour)  n_hour++;
            if (inc_min)   n_min++;
            if (inc_ahour) n_ahour++;
            if (inc_amin)  n_amin++;
            if (sec_clr)   n_sec++;
        end
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        key_mode = 1'b1; step(1); key_mode = 1'b0; step(3);
    endtask

    task automatic press_turn();
        key_turn = 1'b1; step(1); key_turn = 1'b0; step(3);
    endtask

    task automatic press_change();
        key_change = 1'b1; step(1); key_change = 1'b0; step(3);
    endtask

    task automatic tick();
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(2);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; key_mode = 1'b1; step(3);
        checks++; if (state !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state); else passed++;
        checks++; if (run_en !== 1'b1) $display("[TB] FAIL reset_run_en: got %0b expected 1", run_en); else passed++;
        checks++; if ({disp_alarm, LD_hour, LD_min, LD_alert} !== 4'b0000)
            $display("[TB] FAIL reset_lamps: got %b expected 0000", {disp_alarm, LD_hour, LD_min, LD_alert}); else passed++;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (state !== 3'd0 || run_en !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) $display("[TB] FAIL held_mode_state: got %0d bad cycles expected 0", bad); else passed++;
        checks++; if (n_hour + n_min + n_ahour + n_amin + n_sec !== 0)
            $display("[TB] FAIL held_mode_pulses: got %0d expected 0", n_hour + n_min + n_ahour + n_amin + n_sec); else passed++;
        key_mode = 1'b0; step(3);
        checks++; if (state !== 3'd0) $display("[TB] FAIL release_state: got %0d expected 0", state); else passed++;
    endtask

    task automatic test_mode_cycle();
        int exp_state [5] = '{1, 2, 3, 4, 0};
        int exp_run   [5] = '{0, 0, 1, 1, 1};
        int exp_disp  [5] = '{0, 0, 1, 1, 0};
        int exp_sec   [5] = '{0, 0, 1, 0, 0};
        int exp_ld    [5] = '{4, 2, 5, 3, 0};
        int s0;
        for (int i = 0; i < 5; i++) begin
            s0 = n_sec;
            press_mode();
            checks++; if (state !== exp_state[i][2:0]) $display("[TB] FAIL mode_state%0d: got %0d expected %0d", i, state, exp_state[i]); else passed++;
            checks++; if (run_en !== exp_run[i][0]) $display("[TB] FAIL mode_run_en%0d: got %0b expected %0d", i, run_en, exp_run[i]); else passed++;
            checks++; if (disp_alarm !== exp_disp[i][0]) $display("[TB] FAIL mode_disp%0d: got %0b expected %0d", i, disp_alarm, exp_disp[i]); else passed++;
            checks++; if ({LD_hour, LD_min, LD_alert} !== exp_ld[i][2:0])
                $display("[TB] FAIL mode_lamps%0d: got %b expected %b", i, {LD_hour, LD_min, LD_alert}, exp_ld[i][2:0]); else passed++;
            checks++; if (n_sec - s0 !== exp_sec[i]) $display("[TB] FAIL mode_sec_clr%0d: got %0d expected %0d", i, n_sec - s0, exp_sec[i]); else passed++;
        end
    endtask

    task automatic test_hold_repeat();
        int h0, m0, s0;
        press_mode();
        h0 = n_hour; m0 = n_min;
        key_change = 1'b1;
        step(1);
        checks++; if (inc_hour !== 1'b0) $display("[TB] FAIL hold_early: got %0b expected 0", inc_hour); else passed++;
        step(1);
        checks++; if (inc_hour !== 1'b1) $display("[TB] FAIL hold_press_pulse: got %0b expected 1", inc_hour); else passed++;
        step(1);
        checks++; if (inc_hour !== 1'b0) $display("[TB] FAIL hold_pulse_width: got %0b expected 0", inc_hour); else passed++;
        step(16);
        checks++; if (n_hour - h0 !== 1) $display("[TB] FAIL hold_before_repeat: got %0d expected 1", n_hour - h0); else passed++;
        step(1);
        checks++; if (inc_hour !== 1'b1) $display("[TB] FAIL hold_first_repeat: got %0b expected 1", inc_hour); else passed++;
        step(21);
        key_change = 1'b0; step(5);
        checks++; if (n_hour - h0 !== 6) $display("[TB] FAIL hold_total: got %0d expected 6", n_hour - h0); else passed++;
        checks++; if (n_min - m0 !== 0) $display("[TB] FAIL hold_inc_min: got %0d expected 0", n_min - m0); else passed++;
        checks++; if (state !== 3'd1) $display("[TB] FAIL hold_state: got %0d expected 1", state); else passed++;
        s0 = n_sec;
        press_turn();
        checks++; if (state !== 3'd0) $display("[TB] FAIL turn_from_thour: got %0d expected 0", state); else passed++;
        checks++; if (n_sec - s0 !== 0) $display("[TB] FAIL turn_thour_sec_clr: got %0d expected 0", n_sec - s0); else passed++;
    endtask

    task automatic test_mode_over_change();
        int h0, m0, s0;
        press_mode();
        h0 = n_hour; m0 = n_min;
        key_mode = 1'b1; key_change = 1'b1; step(1);
        key_mode = 1'b0; key_change = 1'b0; step(3);
        checks++; if (state !== 3'd2) $display("[TB] FAIL prio_mode_state: got %0d expected 2", state); else passed++;
        checks++; if ((n_hour - h0) + (n_min - m0) !== 0)
            $display("[TB] FAIL prio_mode_inc: got %0d expected 0", (n_hour - h0) + (n_min - m0)); else passed++;
        s0 = n_sec;
        press_turn();
        checks++; if (state !== 3'd0) $display("[TB] FAIL turn_from_tmin: got %0d expected 0", state); else passed++;
        checks++; if (n_sec - s0 !== 1) $display("[TB] FAIL turn_tmin_sec_clr: got %0d expected 1", n_sec - s0); else passed++;
    endtask

    task automatic test_timeout();
        int s0, m0;
        press_mode(); press_mode();
        checks++; if (state !== 3'd2) $display("[TB] FAIL to_enter: got %0d expected 2", state); else passed++;
        tick(); tick();
        checks++; if (state !== 3'd2) $display("[TB] FAIL to_two_ticks: got %0d expected 2", state); else passed++;
        s0 = n_sec;
        tick();
        checks++; if (state !== 3'd0) $display("[TB] FAIL to_third_tick: got %0d expected 0", state); else passed++;
        checks++; if (n_sec - s0 !== 1) $display("[TB] FAIL to_sec_clr: got %0d expected 1", n_sec - s0); else passed++;
        press_mode(); press_mode();
        tick(); tick();
        m0 = n_min;
        press_change();
        checks++; if (n_min - m0 !== 1) $display("[TB] FAIL to_change_pulse: got %0d expected 1", n_min - m0); else passed++;
        tick(); tick();
        checks++; if (state !== 3'd2) $display("[TB] FAIL to_restart: got %0d expected 2", state); else passed++;
        s0 = n_sec;
        tick();
        checks++; if (state !== 3'd0) $display("[TB] FAIL to_after_restart: got %0d expected 0", state); else passed++;
        checks++; if (n_sec - s0 !== 1) $display("[TB] FAIL to_restart_sec_clr: got %0d expected 1", n_sec - s0); else passed++;
    endtask

    task automatic test_turn_mode_coincide();
        int a0, s0;
        press_mode(); press_mode(); press_mode();
        checks++; if (state !== 3'd3) $display("[TB] FAIL co_enter: got %0d expected 3", state); else passed++;
        a0 = n_ahour; s0 = n_sec;
        key_turn = 1'b1; key_mode = 1'b1; key_change = 1'b1; step(1);
        key_turn = 1'b0; key_mode = 1'b0; key_change = 1'b0; step(3);
        checks++; if (state !== 3'd0) $display("[TB] FAIL co_state: got %0d expected 0", state); else passed++;
        checks++; if (n_ahour - a0 !== 0) $display("[TB] FAIL co_inc_ahour: got %0d expected 0", n_ahour - a0); else passed++;
        checks++; if (n_sec - s0 !== 0) $display("[TB] FAIL co_sec_clr: got %0d expected 0", n_sec - s0); else passed++;
        checks++; if (disp_alarm !== 1'b0) $display("[TB] FAIL co_disp: got %0b expected 0", disp_alarm); else passed++;
    endtask

    task automatic test_reset_mid_set();
        int s0;
        press_mode(); press_mode();
        checks++; if (state !== 3'd2) $display("[TB] FAIL mid_enter: got %0d expected 2", state); else passed++;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0) $display("[TB] FAIL mid_async_state: got %0d expected 0", state); else passed++;
        checks++; if ({run_en, sec_clr} !== 2'b10) $display("[TB] FAIL mid_async_out: got %b expected 10", {run_en, sec_clr}); else passed++;
        step(2);
        s0 = n_sec;
        rst_n = 1'b1; step(5);
        checks++; if (n_sec - s0 !== 0) $display("[TB] FAIL mid_sec_clr: got %0d expected 0", n_sec - s0); else passed++;
    endtask

    task automatic test_blink();
`ifdef CLOCK_CTRL_BLINK_EN
        logic exp_ld [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        logic exp_ld [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        press_turn();
        checks++; if (b_state !== 3'd0) $display("[TB] FAIL blink_sync: got %0d expected 0", b_state); else passed++;
        press_mode();
        checks++; if (b_LD_hour !== exp_ld[0]) $display("[TB] FAIL blink_entry: got %0b expected %0b", b_LD_hour, exp_ld[0]); else passed++;
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++; if (b_LD_hour !== exp_ld[i]) $display("[TB] FAIL blink_tick%0d: got %0b expected %0b", i, b_LD_hour, exp_ld[i]); else passed++;
        end
        checks++; if (b_state !== 3'd1) $display("[TB] FAIL no_timeout_state: got %0d expected 1", b_state); else passed++;
        checks++; if (state !== 3'd0) $display("[TB] FAIL timeout_main_state: got %0d expected 0", state); else passed++;
        checks++; if ({b_LD_min, b_LD_alert} !== 2'b00) $display("[TB] FAIL blink_other_lamps: got %b expected 00", {b_LD_min, b_LD_alert}); else passed++;
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] clock_mode_ctrl directed tests start");
        test_reset();
        test_mode_cycle();
        test_hold_repeat();
        test_mode_over_change();
        test_timeout();
        test_turn_mode_coincide();
        test_reset_mid_set();
        test_blink();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Central mode controller for the multi-function digital clock. Sits between the key debouncer and the timekeeping, alarm and display blocks.
- Sequences run / time-set / alarm-set modes and issues single-cycle increment pulses to the hour/minute counters and alarm registers.
- Handles press-and-hold auto-repeat and idle timeout, drives the LD indicator lamps, and selects which time the display shows.

Parameters:
- TIMEOUT_S, 10, idle seconds (tick_1hz counts) in any set state before auto-return to RUN; 0 disables timeout.
- HOLD_CYC, 50000000, clk cycles key_change must stay high before auto-repeat starts.
- REP_CYC, 10000000, clk cycles between auto-repeat increments once repeating.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-clk-wide pulse per second, synchronous to clk
- key_mode  input  1  debounced mode key level, active high
- key_turn  input  1  debounced exit key level, active high
- key_change  input  1  debounced increment key level, active high
- inc_hour  output  1  one-cycle pulse: increment clock hour
- inc_min  output  1  one-cycle pulse: increment clock minute
- inc_ahour  output  1  one-cycle pulse: increment alarm hour
- inc_amin  output  1  one-cycle pulse: increment alarm minute
- sec_clr  output  1  one-cycle pulse: clear clock seconds
- run_en  output  1  timekeeper count enable
- disp_alarm  output  1  1 = display shows alarm time
- LD_hour  output  1  hour-field-being-set lamp
- LD_min  output  1  minute-field-being-set lamp
- LD_alert  output  1  alarm-set-mode lamp
- state  output  3  current state code, for debug

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=RUN(0); all pulses 0; run_en=1; disp_alarm=0; all LD=0; all counters 0.
- Key edge detect: key edge registers reset to 1, so a key held through reset release produces no press.
  - A press is a rising edge of the level. Press strobes are internal, one cycle after the level rises.
- States: RUN=0, T_HOUR=1, T_MIN=2, A_HOUR=3, A_MIN=4. Codes 5-7 are illegal and go to RUN on the next cycle.
- key_mode press advances RUN->T_HOUR->T_MIN->A_HOUR->A_MIN->RUN.
- key_turn press in any set state goes to RUN. In RUN it is ignored.
- Priority when strobes coincide in one cycle: turn > mode > change > timeout. Only the highest-priority action takes effect.
- key_change press in a set state: one increment pulse on the field of the current state, registered, one cycle after the strobe.
  - In RUN, key_change is ignored.
- Auto-repeat while key_change stays high in a set state:
  - hold counter reaches HOLD_CYC → increment pulse;
  - then a pulse every REP_CYC cycles;
  - released or state changes → counters cleared.
- The block does no wrap-around; modulo-24 / modulo-60 wrap is the counters' job.
- sec_clr: single pulse in the same cycle that T_MIN is left, by any cause (mode, turn or timeout).
- run_en = 0 in T_HOUR and T_MIN, otherwise 1. Registered, changes with state.
- disp_alarm = 1 in A_HOUR and A_MIN.
- Lamps: LD_hour active in T_HOUR or A_HOUR. LD_min active in T_MIN or A_MIN. LD_alert = 1 in A_HOUR or A_MIN.
- Idle timeout:
  - counter increments on tick_1hz in set states;
  - cleared on any key press, on any auto-repeat pulse, and on every state change;
  - reaching TIMEOUT_S → RUN on the next cycle.
- Reset mid-operation: reset asserted mid-set returns to RUN immediately. Any in-flight pulse is dropped; sec_clr is not issued.

Optional Feature:
- Macro: CLOCK_CTRL_BLINK_EN.
- Defined: an "active" LD_hour/LD_min lamp blinks. It is on at state entry and toggles on every tick_1hz. The phase is forced on for the cycle after any increment pulse. LD_alert stays steady.
- Undefined: active lamps are steady 1; no blink register exists.

Test Plan:
- Reset with key_mode held high, release rst_n, hold key_mode 100 cycles → state stays 0, no pulses, run_en=1.
- Five key_mode presses → state 1,2,3,4,0. run_en 0 only in states 1-2. sec_clr exactly one pulse on the 2->3 transition. disp_alarm 1 in states 3-4.
- HOLD_CYC=20, REP_CYC=5, state 1, hold key_change 41 cycles → one press pulse, then auto-repeat pulses at hold counts 20, 25, 30, 35, 40. Total 6 inc_hour pulses; inc_min stays 0.
- TIMEOUT_S=3, state 2, issue 3 tick_1hz with no keys → state returns to 0 after the third tick, sec_clr pulses once. Repeat with a key_change press between ticks → no timeout until 3 further ticks.
- State 3, key_turn and key_mode rise in the same cycle → state 0, no inc_ahour, no sec_clr.
- With CLOCK_CTRL_BLINK_EN, state 1, issue 4 ticks → LD_hour sequence 1,0,1,0,1. Without the macro → LD_hour constant 1.
